seg7_scan: RTL and testbench

Time-multiplexed seven-segment display driver that consumes the one-cycle tick from the board clock divider. Each tick advances the scan to the next digit. The block decodes a hex nibble per digit and drives active-low anode and segment lines. The displayed value is snapshotted once per frame, so a processor value that changes mid-frame (PC, register, ALU result) never tears across digits.

---
 rtl/seg7_scan_if.sv | 13 +
 rtl/seg7_scan.sv | 91 +++++++++
 tb/tb_seg7_scan.sv | 134 +++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: scan-driver bundle; master drives tick/value/dp_in/digit_en, slave returns an/seg/dp/frame_done
interface seg7_scan_if #(parameter int DIGITS = 4);
  logic                  tick;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     digit_en;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  frame_done;
  modport master (output tick, value, dp_in, digit_en, input an, seg, dp, frame_done);
  modport slave (input tick, value, dp_in, digit_en, output an, seg, dp, frame_done);
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed active-low seven-segment driver with per-frame snapshot
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus.tick     : advance pulse; bus.value/dp_in/digit_en : latched at each frame wrap
//   bus.an/seg/dp: registered active-low drive; bus.frame_done: one-cycle pulse per frame
//   SEG7_LZB_EN  : when defined, leading zeros above the top nonzero nibble are blanked
module seg7_scan #(parameter int DIGITS = 4) (
  input logic       clock,
  input logic       reset,
  seg7_scan_if.slave bus
);
  localparam int IW = $clog2(DIGITS);
  typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [4*DIGITS-1:0] val_snap;
  logic [DIGITS-1:0] dp_snap, mask_snap, lz, an_n;
  logic [6:0] seg_n;
  logic dp_n, wrap, wrap_q, lit;
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction
`ifdef SEG7_LZB_EN
  logic lz_run;
  // Scan from the top digit down; a digit is blank while every nibble at or above it is zero.
  always_comb begin
    lz = '0;
    lz_run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lz_run = lz_run && (val_snap[4*i +: 4] == 4'h0);
      lz[i] = lz_run;
    end
  end
`else
  assign lz = '0;
`endif
  always_comb begin
    wrap = bus.tick && (idx == IW'(DIGITS - 1));
    idx_n = bus.tick ? (wrap ? '0 : idx + 1'b1) : idx;
    state_n = bus.tick ? BLANK : (state == BLANK ? SHOW : state);
    lit = (state == SHOW) && mask_snap[idx] && !lz[idx];
    an_n = lit ? ~(DIGITS'(1) << idx) : '1;
    seg_n = lit ? seg_decode(val_snap[4*idx +: 4]) : 7'h7F;
    dp_n = lit ? ~dp_snap[idx] : 1'b1;
  end
  // Outputs are registered from the current state, so a tick shows BLANK one edge
  // after it is sampled and the new digit one edge after that.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= OFF;
      idx <= IW'(DIGITS - 1);
      val_snap <= '0;
      dp_snap <= '0;
      mask_snap <= '0;
      wrap_q <= 1'b0;
      bus.an <= '1;
      bus.seg <= 7'h7F;
      bus.dp <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      wrap_q <= wrap;
      bus.frame_done <= wrap_q;
      bus.an <= an_n;
      bus.seg <= seg_n;
      bus.dp <= dp_n;
      if (wrap) begin
        val_snap <= bus.value;
        dp_snap <= bus.dp_in;
        mask_snap <= bus.digit_en;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scoreboard bench for seg7_scan (DIGITS = 4)
module tb_seg7_scan;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  typedef struct {
    int          c;
    logic [12:0] v;
    string       tag;
  } exp_t;
  exp_t sb[$];
  seg7_scan_if #(.DIGITS(4)) bus();
  seg7_scan #(.DIGITS(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got an/seg/dp/fd=%h expected %h", tag, cyc, got, exp);
  endtask
  function automatic void push(input int c, input logic [3:0] a, input logic [6:0] s,
                               input logic d, input logic f, input string tag);
    exp_t e;
    e.c = c;
    e.v = {a, s, d, f};
    e.tag = tag;
    sb.push_back(e);
  endfunction
  always @(negedge clock)
    while (sb.size() != 0 && sb[0].c <= cyc) begin
      check(sb[0].tag, {bus.an, bus.seg, bus.dp, bus.frame_done}, sb[0].v);
      void'(sb.pop_front());
    end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic slot(input logic [3:0] a, input logic [6:0] s, input logic d,
                      input logic f, input string tag);
    int c;
    c = cyc;
    bus.tick = 1'b1;
    push(c + 2, 4'hF, 7'h7F, 1'b1, f, {tag, "_blank"});
    push(c + 3, a, s, d, 1'b0, {tag, "_show"});
    push(c + 9, a, s, d, 1'b0, {tag, "_hold"});
    step();
    bus.tick = 1'b0;
    repeat (8) step();
  endtask
  initial begin
    int c;
    bit lzb;
`ifdef SEG7_LZB_EN
    lzb = 1'b1;
`else
    lzb = 1'b0;
`endif
    bus.tick = 1'b0;
    bus.value = 16'h12A4;
    bus.dp_in = 4'h0;
    bus.digit_en = 4'hF;
    repeat (3) step();
    reset = 1'b0;
    c = cyc;
    for (int i = 1; i <= 1000; i++) push(c + i, 4'hF, 7'h7F, 1'b1, 1'b0, "idle");
    repeat (1000) step();
    slot(4'b1110, 7'h19, 1'b1, 1'b1, "f1d0");
    slot(4'b1101, 7'h08, 1'b1, 1'b0, "f1d1");
    bus.value = 16'hFFFF;
    slot(4'b1011, 7'h24, 1'b1, 1'b0, "f1d2");
    slot(4'b0111, 7'h79, 1'b1, 1'b0, "f1d3");
    slot(4'b1110, 7'h0E, 1'b1, 1'b1, "f2d0");
    slot(4'b1101, 7'h0E, 1'b1, 1'b0, "f2d1");
    slot(4'b1011, 7'h0E, 1'b1, 1'b0, "f2d2");
    bus.digit_en = 4'b1011;
    bus.dp_in = 4'b0100;
    slot(4'b0111, 7'h0E, 1'b1, 1'b0, "f2d3");
    slot(4'b1110, 7'h0E, 1'b1, 1'b1, "f3d0");
    slot(4'b1101, 7'h0E, 1'b1, 1'b0, "f3d1");
    slot(4'hF, 7'h7F, 1'b1, 1'b0, "f3d2_mask");
    bus.value = 16'h0030;
    bus.digit_en = 4'hF;
    bus.dp_in = 4'b1000;
    slot(4'b0111, 7'h0E, 1'b1, 1'b0, "f3d3");
    slot(4'b1110, 7'h40, 1'b1, 1'b1, "f4d0");
    slot(4'b1101, 7'h30, 1'b1, 1'b0, "f4d1");
    if (lzb) begin
      slot(4'hF, 7'h7F, 1'b1, 1'b0, "f4d2_lz");
      slot(4'hF, 7'h7F, 1'b1, 1'b0, "f4d3_lz");
    end else begin
      slot(4'b1011, 7'h40, 1'b1, 1'b0, "f4d2");
      slot(4'b0111, 7'h40, 1'b0, 1'b0, "f4d3");
    end
    c = cyc;
    reset = 1'b1;
    for (int i = 1; i <= 5; i++) push(c + i, 4'hF, 7'h7F, 1'b1, 1'b0, "rst_show");
    step();
    reset = 1'b0;
    repeat (4) step();
    c = cyc;
    reset = 1'b1;
    bus.tick = 1'b1;
    for (int i = 1; i <= 4; i++) push(c + i, 4'hF, 7'h7F, 1'b1, 1'b0, "rst_tick");
    step();
    reset = 1'b0;
    bus.tick = 1'b0;
    repeat (3) step();
    slot(4'b1110, 7'h40, 1'b1, 1'b1, "restart_d0");
    c = cyc;
    bus.tick = 1'b1;
    push(c + 2, 4'hF, 7'h7F, 1'b1, 1'b0, "dbl_blank1");
    push(c + 3, 4'hF, 7'h7F, 1'b1, 1'b0, "dbl_blank2");
    if (lzb) begin
      push(c + 4, 4'hF, 7'h7F, 1'b1, 1'b0, "dbl_d2_lz");
      push(c + 6, 4'hF, 7'h7F, 1'b1, 1'b0, "dbl_d2_lz_hold");
    end else begin
      push(c + 4, 4'b1011, 7'h40, 1'b1, 1'b0, "dbl_d2");
      push(c + 6, 4'b1011, 7'h40, 1'b1, 1'b0, "dbl_d2_hold");
    end
    step();
    step();
    bus.tick = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
